// File: rtl/vc_test_rand_sink_if.sv
// Val/rdy message channel between a producer (master) and vc_test_rand_sink (slave).
interface vc_test_rand_sink_if #(
  parameter int unsigned p_msg_sz = 1
);
  logic                val;
  logic                rdy;
  logic [p_msg_sz-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/vc_test_rand_sink.sv
// vc_test_rand_sink: test sink that checks each accepted message against a bench-preloaded
// expected-message memory, throttles rdy with an LFSR-driven delay and counts received and
// mismatching messages.
// Build option: define VC_TEST_SINK_MASK_EN to compile in the per-entry don't-care mask memory
// (mk) and the masked compare; otherwise every bit of the message is compared exactly.
module vc_test_rand_sink #(
  parameter int unsigned p_msg_sz    = 1,
  parameter int unsigned p_mem_sz    = 1024,
  parameter int unsigned p_max_delay = 0,
  parameter logic [15:0] p_seed      = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  vc_test_rand_sink_if.slave         sink,
  input  logic [$clog2(p_mem_sz):0]  num_msgs,
  output logic                       done,
  output logic [$clog2(p_mem_sz):0]  num_recv,
  output logic [15:0]                num_err
);

  localparam int unsigned CntW     = $clog2(p_mem_sz) + 1;
  localparam int unsigned AddrW    = (p_mem_sz > 1) ? $clog2(p_mem_sz) : 1;
  localparam logic [7:0]  DlyMask  = 8'(p_max_delay);
  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {StReady, StWait, StDone} state_e;

  // Expected messages (and masks), written hierarchically by the bench; reset leaves them alone.
  logic [p_msg_sz-1:0] m [p_mem_sz];
`ifdef VC_TEST_SINK_MASK_EN
  logic [p_msg_sz-1:0] mk [p_mem_sz];
`endif

  state_e          state_q;
  logic [CntW-1:0] index_q;
  logic [7:0]      dly_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     err_q;

  logic                rdy_int;
  logic                go;
  logic                miss;
  logic [AddrW-1:0]    addr;
  logic [p_msg_sz-1:0] exp_msg;
  logic [p_msg_sz-1:0] got_msg;
  logic [CntW-1:0]     index_inc;
  logic [7:0]          dly_load;
  logic [15:0]         lfsr_next;

  // rdy is a pure decode of the state register, so there is no val->rdy path.
  assign rdy_int  = (state_q == StReady);
  assign sink.rdy = rdy_int;
  assign done     = (index_q == num_msgs);
  assign num_recv = index_q;
  assign num_err  = err_q;

  // Accept decode, expected-vs-received compare and next delay / LFSR values.
  always_comb begin
    go        = sink.val && rdy_int;
    addr      = index_q[AddrW-1:0];
`ifdef VC_TEST_SINK_MASK_EN
    exp_msg   = m[addr] & mk[addr];
    got_msg   = sink.msg & mk[addr];
`else
    exp_msg   = m[addr];
    got_msg   = sink.msg;
`endif
    // 4-state compare: X/Z on the received message is a mismatch.
    miss      = (got_msg !== exp_msg);
    index_inc = index_q + 1'b1;
    dly_load  = lfsr_q[7:0] & DlyMask;
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  end

  // Sink FSM with index, delay, LFSR and error registers; reset beats a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (num_msgs == '0) ? StDone : StReady;
      index_q <= '0;
      dly_q   <= '0;
      lfsr_q  <= p_seed;
      err_q   <= '0;
    end else begin
      // Free-running so the delay sequence depends only on cycles since reset.
      lfsr_q <= lfsr_next;
      case (state_q)
        StReady: begin
          if (go) begin
            index_q <= index_inc;
            dly_q   <= dly_load;
            if (miss && (err_q != 16'hFFFF)) begin
              err_q <= err_q + 16'd1;
            end
            // Finishing wins over a pending delay so rdy never reopens once done.
            if (index_inc == num_msgs) begin
              state_q <= StDone;
            end else if (dly_load != 8'd0) begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          dly_q <= dly_q - 8'd1;
          if (dly_q == 8'd1) begin
            state_q <= StReady;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StDone;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  logic chk_armed_q;

  // Simulation-only reporting: mismatch details and an out-of-range message count.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_armed_q <= 1'b1;
    end else begin
      chk_armed_q <= 1'b0;
      if (chk_armed_q && (num_msgs > CntW'(p_mem_sz))) begin
        $display("vc_test_rand_sink: num_msgs %0d exceeds memory depth %0d", num_msgs, p_mem_sz);
        $fatal(1, "vc_test_rand_sink: illegal num_msgs");
      end
      if (go && miss) begin
        $display("vc_test_rand_sink: index %0d expected %h received %h", index_q, exp_msg,
                 got_msg);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_test_rand_sink.sv
// Directed bench for vc_test_rand_sink: two instances (full throughput and random delay),
// expected counters queued per accept and compared on the following cycle.
module tb_vc_test_rand_sink;

  localparam int unsigned MsgSz = 8;
  localparam int unsigned MemSz = 16;
  localparam int unsigned CntW  = 5;
  localparam logic [15:0] Seed  = 16'hACE1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc_test_rand_sink_if #(.p_msg_sz(MsgSz)) bus0 ();
  vc_test_rand_sink_if #(.p_msg_sz(MsgSz)) bus1 ();

  logic [CntW-1:0] num_msgs0, num_msgs1, num_recv0, num_recv1;
  logic            done0, done1;
  logic [15:0]     num_err0, num_err1;

  vc_test_rand_sink #(
    .p_msg_sz(MsgSz), .p_mem_sz(MemSz), .p_max_delay(0), .p_seed(Seed)
  ) dut0 (
    .clk(clk), .reset(reset), .sink(bus0.slave), .num_msgs(num_msgs0),
    .done(done0), .num_recv(num_recv0), .num_err(num_err0)
  );

  vc_test_rand_sink #(
    .p_msg_sz(MsgSz), .p_mem_sz(MemSz), .p_max_delay(7), .p_seed(Seed)
  ) dut1 (
    .clk(clk), .reset(reset), .sink(bus1.slave), .num_msgs(num_msgs1),
    .done(done1), .num_recv(num_recv1), .num_err(num_err1)
  );

  typedef struct {
    int recv;
    int err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] tx [MemSz];
  logic [7:0] em [MemSz];
  logic [7:0] ek [MemSz];
  int         ncomp = 0;
  int         nfail = 0;

  // Reference LFSR: feedback bit re-enters at bit 15 and is xored into bits 13, 12 and 10.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic       fb;
    logic [15:0] y;
    fb    = x[0];
    y     = {fb, x[15:1]};
    y[13] = y[13] ^ fb;
    y[12] = y[12] ^ fb;
    y[10] = y[10] ^ fb;
    return y;
  endfunction

  logic [15:0] mlfsr;
  always @(posedge clk) mlfsr <= reset ? Seed : lfsr_step(mlfsr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_miss(input int k);
`ifdef VC_TEST_SINK_MASK_EN
    return (tx[k] & ek[k]) !== (em[k] & ek[k]);
`else
    return tx[k] !== em[k];
`endif
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? bus0.rdy : bus1.rdy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  function automatic int get_recv(input int sel);
    return (sel == 0) ? int'(num_recv0) : int'(num_recv1);
  endfunction

  function automatic int get_err(input int sel);
    return (sel == 0) ? int'(num_err0) : int'(num_err1);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus0.val = v;
      bus0.msg = d;
    end else begin
      bus1.val = v;
      bus1.msg = d;
    end
  endtask

  task automatic load(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        dut0.m[i] = em[i];
`ifdef VC_TEST_SINK_MASK_EN
        dut0.mk[i] = ek[i];
`endif
      end else begin
        dut1.m[i] = em[i];
`ifdef VC_TEST_SINK_MASK_EN
        dut1.mk[i] = ek[i];
`endif
      end
    end
  endtask

  // Ends at a negedge with reset freshly deasserted; reset-state outputs are visible there.
  task automatic do_reset();
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_check(input int sel);
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("num_recv", get_recv(sel), e.recv);
      check("num_err", get_err(sel), e.err);
    end
  endtask

  // Sends tx[0..n-1] with val held high; checks counters after every accept and, for each rdy
  // gap, that its length equals the delay predicted from the reference LFSR.
  task automatic stream(input int sel, input int n, input int maxd, input bit fin);
    int   k       = 0;
    int   gap     = 0;
    int   exp_gap = 0;
    int   cyc     = 0;
    int   err_exp = 0;
    bit   seen    = 1'b0;
    exp_t e;
    while (k < n) begin
      @(negedge clk);
      pop_check(sel);
      cyc++;
      if (cyc > 600) begin
        check("stream_timeout", k, n);
        break;
      end
      drive(sel, 1'b1, tx[k]);
      if (get_rdy(sel)) begin
        if (seen) check("rdy_gap", gap, exp_gap);
        exp_gap = int'(mlfsr[7:0]) & maxd;
        seen    = 1'b1;
        gap     = 0;
        if (is_miss(k)) err_exp++;
        e.recv = k + 1;
        e.err  = err_exp;
        sbq.push_back(e);
        k++;
      end else begin
        gap++;
      end
    end
    @(negedge clk);
    pop_check(sel);
    drive(sel, 1'b0, 8'h00);
    check("done_end", get_done(sel), fin);
    if (fin) check("rdy_done", get_rdy(sel), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MemSz; i++) ek[i] = 8'hFF;
    bus0.val  = 1'b0;
    bus0.msg  = 8'h00;
    bus1.val  = 1'b0;
    bus1.msg  = 8'h00;
    num_msgs0 = 5'd4;
    num_msgs1 = 5'd0;

    // Reset state, and num_msgs == 0 boundary on dut1.
    do_reset();
    check("rst_rdy0", bus0.rdy, 1'b1);
    check("rst_done0", done0, 1'b0);
    check("rst_recv0", num_recv0, 0);
    check("rst_err0", num_err0, 0);
    check("zero_done1", done1, 1'b1);
    check("zero_rdy1", bus1.rdy, 1'b0);
    drive(1, 1'b1, 8'h55);
    repeat (3) @(negedge clk);
    check("zero_rdy1_hold", bus1.rdy, 1'b0);
    check("zero_recv1_hold", num_recv1, 0);
    drive(1, 1'b0, 8'h00);

    // Basic stream at full throughput.
    for (int i = 0; i < 4; i++) begin
      em[i] = 8'(i + 1);
      tx[i] = 8'(i + 1);
    end
    load(0, 4);
    do_reset();
    stream(0, 4, 0, 1'b1);
    check("basic_recv", num_recv0, 4);
    check("basic_err", num_err0, 0);

    // Mismatch on the third message.
    em[2] = 8'h03;
    tx[2] = 8'h07;
    load(0, 4);
    do_reset();
    stream(0, 4, 0, 1'b1);
    check("mis_err", num_err0, 1);

    // Don't-care mask on entry 0.
    num_msgs0 = 5'd1;
    em[0] = 8'hA5;
    ek[0] = 8'hF0;
    tx[0] = 8'hAF;
    load(0, 1);
    do_reset();
    stream(0, 1, 0, 1'b1);
`ifdef VC_TEST_SINK_MASK_EN
    check("mask_err", num_err0, 0);
`else
    check("mask_err", num_err0, 1);
`endif
    ek[0] = 8'hFF;

    // Reset mid-run, colliding with an accept, then a full replay.
    num_msgs0 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      em[i] = 8'(8'h11 * (i + 1));
      tx[i] = em[i];
    end
    load(0, 4);
    do_reset();
    stream(0, 2, 0, 1'b0);
    check("mid_recv2", num_recv0, 2);
    check("mid_rdy", bus0.rdy, 1'b1);
    drive(0, 1'b1, tx[2]);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_recv", num_recv0, 0);
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    stream(0, 4, 0, 1'b1);
    check("mid_final_recv", num_recv0, 4);
    check("mid_final_err", num_err0, 0);

    // num_msgs == p_mem_sz: every entry checked, count reaches 16 without wrapping.
    num_msgs0 = 5'(MemSz);
    for (int i = 0; i < MemSz; i++) begin
      em[i] = 8'($urandom_range(0, 255));
      tx[i] = em[i];
    end
    load(0, MemSz);
    do_reset();
    stream(0, MemSz, 0, 1'b1);
    check("full_recv", num_recv0, MemSz);
    check("full_err", num_err0, 0);

    // Random ready delay on dut1.
    num_msgs1 = 5'(MemSz);
    for (int i = 0; i < MemSz; i++) begin
      em[i] = 8'($urandom_range(0, 255));
      tx[i] = em[i];
    end
    load(1, MemSz);
    do_reset();
    stream(1, MemSz, 7, 1'b1);
    check("rand_recv", num_recv1, MemSz);
    check("rand_err", num_err1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
